// File: rtl/aether_pifo_pkg.sv
// Shared types for the PIFO front end: the {meta, prio} entry layout and the
// per-cycle command issued to the PIFO tree.
package aether_pifo_pkg;

    localparam int PRIO_W = 16;
    localparam int META_W = 32;

    typedef struct packed {
        logic [META_W-1:0] meta;
        logic [PRIO_W-1:0] prio;
    } entry_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2
    } op_t;

    // Encoding of the one-bit round-robin history register.
    localparam logic GRANT_PUSH = 1'b0;
    localparam logic GRANT_POP  = 1'b1;

endpackage

// File: rtl/aether_pifo_result_fifo.sv
// Show-ahead synchronous FIFO holding PIFO pop results until the consumer
// takes them; a write and a read may share a cycle even when full.
module aether_pifo_result_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          not_empty,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_rd;
    logic          do_wr;

    always_comb begin
        do_rd = rd_en && (count_reg != '0);
        // A full buffer can still accept a write when the head leaves this cycle.
        do_wr = wr_en && ((count_reg != CW'(DEPTH)) || do_rd);
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data   = mem[rd_ptr_reg];
    assign not_empty = (count_reg != '0);
    assign count     = count_reg;

endmodule

// File: rtl/aether_pifo_frontend.sv
// Front end for a PIFO tree: arbitrates push/pop commands, tracks occupancy,
// and buffers pop results with credit so a stalled consumer never loses data.
module aether_pifo_frontend
    import aether_pifo_pkg::*;
#(
    parameter int PTW       = 16,
    parameter int MTW       = 32,
    parameter int CAPACITY  = 87380,
    parameter int POP_LAT   = 2,
    parameter int OUT_DEPTH = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_enq_valid,
    output logic                           o_enq_ready,
    input  logic [MTW+PTW-1:0]             i_enq_data,
    input  logic                           i_deq_req,
    output logic                           o_deq_req_ready,
    output logic                           o_push,
    output logic                           o_pop,
    output logic [MTW+PTW-1:0]             o_data,
    input  logic                           i_pifo_ready,
    input  logic [MTW+PTW-1:0]             i_pifo_data,
    output logic                           o_deq_valid,
    input  logic                           i_deq_ready,
    output logic [MTW+PTW-1:0]             o_deq_data,
    output logic [$clog2(CAPACITY+1)-1:0]  o_count,
    output logic                           o_full,
    output logic                           o_empty
);
    localparam int W   = MTW + PTW;
    localparam int CW  = $clog2(CAPACITY + 1);
    localparam int IFW = $clog2(POP_LAT + 1);
    localparam int FCW = $clog2(OUT_DEPTH + 1);
    localparam int CRW = $clog2(OUT_DEPTH + POP_LAT + 1) + 1;

    logic [CW-1:0]      count_reg;
    logic               last_grant_reg;
    logic [POP_LAT-1:0] inflight_sr_reg;
    logic [IFW-1:0]     in_flight;
    logic [FCW-1:0]     buf_count;
    logic               credit_ok;
    logic               push_elig;
    logic               pop_elig;
    op_t                op;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < POP_LAT; i++) begin
            in_flight = in_flight + IFW'(inflight_sr_reg[i]);
        end
    end

    // Every slot of the result buffer is either filled or reserved by a pop still in the tree.
    assign credit_ok = (CRW'(in_flight) + CRW'(buf_count)) < CRW'(OUT_DEPTH);

    always_comb begin
        push_elig = !i_rst && i_enq_valid && i_pifo_ready && (count_reg < CW'(CAPACITY));
        pop_elig  = !i_rst && i_deq_req && i_pifo_ready && (count_reg != '0) && credit_ok;
        op        = OP_NONE;
        if (push_elig && pop_elig) begin
            op = (last_grant_reg == GRANT_POP) ? OP_PUSH : OP_POP;
        end else if (push_elig) begin
            op = OP_PUSH;
        end else if (pop_elig) begin
            op = OP_POP;
        end
    end

    assign o_push          = (op == OP_PUSH);
    assign o_pop           = (op == OP_POP);
    assign o_enq_ready     = o_push;
    assign o_deq_req_ready = o_pop;
    assign o_data          = o_push ? i_enq_data : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_reg       <= '0;
            last_grant_reg  <= GRANT_POP;
            inflight_sr_reg <= '0;
        end else begin
            case (op)
                OP_PUSH: count_reg <= count_reg + CW'(1);
                OP_POP:  count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            // History only moves on contention so lone requests never skew fairness.
            if (push_elig && pop_elig) begin
                last_grant_reg <= (op == OP_POP) ? GRANT_POP : GRANT_PUSH;
            end
            inflight_sr_reg[0] <= (op == OP_POP);
            for (int i = 1; i < POP_LAT; i++) begin
                inflight_sr_reg[i] <= inflight_sr_reg[i-1];
            end
        end
    end

    aether_pifo_result_fifo #(
        .W     (W),
        .DEPTH (OUT_DEPTH),
        .CW    (FCW)
    ) u_result_fifo (
        .clk       (i_clk),
        .srst      (i_rst),
        .wr_en     (inflight_sr_reg[POP_LAT-1]),
        .wr_data   (i_pifo_data),
        .rd_en     (i_deq_ready),
        .rd_data   (o_deq_data),
        .not_empty (o_deq_valid),
        .count     (buf_count)
    );

    assign o_count = count_reg;
    assign o_full  = (count_reg == CW'(CAPACITY));
    assign o_empty = (count_reg == '0);

endmodule

// File: tb/tb_aether_pifo_frontend.sv
// Directed bench for the PIFO front end with a behavioural PIFO tree that
// returns the lowest-priority entry POP_LAT cycles after each pop command.
module tb_aether_pifo_frontend;
    localparam int PTW = 16;
    localparam int MTW = 32;
    localparam int W   = MTW + PTW;
    localparam int CAP = 4;
    localparam int PL  = 2;
    localparam int OD  = 4;
    localparam int CW  = $clog2(CAP + 1);

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_enq_valid = 1'b0;
    logic          o_enq_ready;
    logic [W-1:0]  i_enq_data = '0;
    logic          i_deq_req = 1'b0;
    logic          o_deq_req_ready;
    logic          o_push;
    logic          o_pop;
    logic [W-1:0]  o_data;
    logic          i_pifo_ready = 1'b1;
    logic [W-1:0]  i_pifo_data;
    logic          o_deq_valid;
    logic          i_deq_ready = 1'b0;
    logic [W-1:0]  o_deq_data;
    logic [CW-1:0] o_count;
    logic          o_full;
    logic          o_empty;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    aether_pifo_frontend #(
        .PTW(PTW), .MTW(MTW), .CAPACITY(CAP), .POP_LAT(PL), .OUT_DEPTH(OD)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_enq_valid(i_enq_valid), .o_enq_ready(o_enq_ready), .i_enq_data(i_enq_data),
        .i_deq_req(i_deq_req), .o_deq_req_ready(o_deq_req_ready),
        .o_push(o_push), .o_pop(o_pop), .o_data(o_data),
        .i_pifo_ready(i_pifo_ready), .i_pifo_data(i_pifo_data),
        .o_deq_valid(o_deq_valid), .i_deq_ready(i_deq_ready), .o_deq_data(o_deq_data),
        .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
    );

    // Behavioural PIFO tree: stable min-priority extraction, fixed pop latency.
    logic [W-1:0] tree_q [$];
    logic [W-1:0] pipe [PL];
    assign i_pifo_data = pipe[PL-1];

    always @(posedge i_clk) begin
        logic [W-1:0] popped;
        int best;
        popped = '0;
        if (i_rst) begin
            tree_q.delete();
        end else begin
            if (o_pop && tree_q.size() > 0) begin
                best = 0;
                for (int k = 1; k < tree_q.size(); k++)
                    if (tree_q[k][PTW-1:0] < tree_q[best][PTW-1:0]) best = k;
                popped = tree_q[best];
                tree_q.delete(best);
            end
            if (o_push) tree_q.push_back(o_data);
        end
        pipe[0] <= popped;
        for (int k = 1; k < PL; k++) pipe[k] <= pipe[k-1];
    end

    function automatic logic [W-1:0] mk(input int prio, input int meta);
        return {MTW'(meta), PTW'(prio)};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_one(input int prio, input int meta);
        i_enq_valid = 1'b1;
        i_enq_data  = mk(prio, meta);
        tick();
        i_enq_valid = 1'b0;
        $display("push prio=%0d meta=%0d count=%0d", prio, meta, o_count);
    endtask

    task automatic pop_all();
        i_deq_ready = 1'b1;
        i_deq_req   = 1'b1;
        repeat (12) tick();
        i_deq_req = 1'b0;
        repeat (4) tick();
        i_deq_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        i_enq_valid = 1'b1;
        i_enq_data  = mk(9, 9);
        #1;
        total++; if (o_enq_ready !== 1'b0) begin bad++; $display("FAIL rst_enq_ready got=%0b want=0", o_enq_ready); end
        total++; if (o_push !== 1'b0) begin bad++; $display("FAIL rst_push got=%0b want=0", o_push); end
        i_enq_valid = 1'b0;
        tick();
        i_rst = 1'b0;
        #1;
        total++; if (o_count !== CW'(0)) begin bad++; $display("FAIL rst_count got=%0d want=0", o_count); end
        total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%0b want=1", o_empty); end
        total++; if (o_full !== 1'b0) begin bad++; $display("FAIL rst_full got=%0b want=0", o_full); end
        total++; if (o_deq_valid !== 1'b0) begin bad++; $display("FAIL rst_deq_valid got=%0b want=0", o_deq_valid); end
        total++; if (o_pop !== 1'b0) begin bad++; $display("FAIL rst_pop got=%0b want=0", o_pop); end
        $display("reset released");
    endtask

    task automatic test_ordering();
        int prios [3] = '{5, 1, 3};
        int exp_p [3] = '{1, 3, 5};
        int exp_m [3] = '{101, 102, 100};
        logic [W-1:0] exp_d;
        int lat;
        for (int i = 0; i < 3; i++) begin
            i_enq_valid = 1'b1;
            exp_d       = mk(prios[i], 100 + i);
            i_enq_data  = exp_d;
            #1;
            total++; if (o_push !== 1'b1 || o_enq_ready !== 1'b1) begin bad++; $display("FAIL ord_push%0d got=%0b/%0b want=1/1", i, o_push, o_enq_ready); end
            total++; if (o_data !== exp_d) begin bad++; $display("FAIL ord_data%0d got=%0h want=%0h", i, o_data, exp_d); end
            tick();
            $display("push prio=%0d count=%0d", prios[i], o_count);
        end
        i_enq_valid = 1'b0;
        #1;
        total++; if (o_count !== CW'(3)) begin bad++; $display("FAIL ord_count got=%0d want=3", o_count); end
        for (int j = 0; j < 3; j++) begin
            i_deq_req = 1'b1;
            #1;
            total++; if (o_deq_req_ready !== 1'b1) begin bad++; $display("FAIL ord_req_ready%0d got=%0b want=1", j, o_deq_req_ready); end
            tick();
            i_deq_req = 1'b0;
            lat = 1;
            while (o_deq_valid !== 1'b1 && lat < 10) begin
                tick();
                lat++;
            end
            exp_d = mk(exp_p[j], exp_m[j]);
            total++; if (lat != PL + 1) begin bad++; $display("FAIL ord_latency%0d got=%0d want=%0d", j, lat, PL + 1); end
            total++; if (o_deq_data !== exp_d) begin bad++; $display("FAIL ord_deq_data%0d got=%0h want=%0h", j, o_deq_data, exp_d); end
            $display("deq prio=%0d lat=%0d", o_deq_data[PTW-1:0], lat);
            i_deq_ready = 1'b1;
            tick();
            i_deq_ready = 1'b0;
            #1;
            total++; if (o_deq_valid !== 1'b0) begin bad++; $display("FAIL ord_consumed%0d got=%0b want=0", j, o_deq_valid); end
        end
        total++; if (o_count !== CW'(0) || o_empty !== 1'b1) begin bad++; $display("FAIL ord_final got=%0d/%0b want=0/1", o_count, o_empty); end
    endtask

    task automatic test_alternate();
        logic       exp_push [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int         exp_cnt  [4] = '{3, 2, 3, 2};
        int         got [4];
        int         n;
        push_one(10, 200);
        push_one(20, 201);
        total++; if (o_count !== CW'(2)) begin bad++; $display("FAIL alt_start got=%0d want=2", o_count); end
        i_enq_valid = 1'b1;
        i_deq_req   = 1'b1;
        i_deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_enq_data = mk(30 + 10 * i, 210 + i);
            #1;
            total++; if (o_push !== exp_push[i] || o_pop !== !exp_push[i]) begin bad++; $display("FAIL alt_grant%0d got=%0b%0b want=%0b%0b", i, o_push, o_pop, exp_push[i], !exp_push[i]); end
            if (!exp_push[i]) begin
                total++; if (o_data !== '0) begin bad++; $display("FAIL alt_pop_data%0d got=%0h want=0", i, o_data); end
            end
            tick();
            total++; if (o_count !== CW'(exp_cnt[i])) begin bad++; $display("FAIL alt_count%0d got=%0d want=%0d", i, o_count, exp_cnt[i]); end
            $display("alt cycle=%0d push=%0b count=%0d", i, exp_push[i], o_count);
        end
        i_enq_valid = 1'b0;
        i_deq_req   = 1'b0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (o_deq_valid === 1'b1 && n < 4) begin got[n] = int'(o_deq_data[PTW-1:0]); n++; end
            tick();
        end
        total++; if (n != 2) begin bad++; $display("FAIL alt_results got=%0d want=2", n); end
        else begin
            total++; if (got[0] != 10 || got[1] != 20) begin bad++; $display("FAIL alt_order got=%0d,%0d want=10,20", got[0], got[1]); end
        end
        pop_all();
        total++; if (o_count !== CW'(0)) begin bad++; $display("FAIL alt_drain got=%0d want=0", o_count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            i_enq_valid = 1'b1;
            i_enq_data  = mk(60 + i, 300 + i);
            #1;
            if (i == 4) begin
                total++; if (o_full !== 1'b1 || o_count !== CW'(CAP)) begin bad++; $display("FAIL full_flag got=%0b/%0d want=1/%0d", o_full, o_count, CAP); end
            end
            total++; if (o_enq_ready !== (i < 4)) begin bad++; $display("FAIL full_ready%0d got=%0b want=%0b", i, o_enq_ready, (i < 4)); end
            tick();
            $display("push attempt=%0d count=%0d", i, o_count);
        end
        i_enq_valid = 1'b0;
        pop_all();
        i_deq_req = 1'b1;
        #1;
        total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL empty_flag got=%0b want=1", o_empty); end
        total++; if (o_deq_req_ready !== 1'b0 || o_pop !== 1'b0) begin bad++; $display("FAIL empty_pop got=%0b/%0b want=0/0", o_deq_req_ready, o_pop); end
        i_deq_req = 1'b0;
    endtask

    task automatic test_credit();
        int acc;
        int adm;
        int first_adm;
        int n;
        int got [8];
        i_deq_ready = 1'b0;
        push_one(4, 400);
        push_one(3, 401);
        push_one(2, 402);
        push_one(1, 403);
        i_deq_req = 1'b1;
        acc = 0;
        repeat (8) begin
            #1;
            if (o_deq_req_ready === 1'b1) acc++;
            tick();
        end
        i_deq_req = 1'b0;
        total++; if (acc != 4) begin bad++; $display("FAIL credit_first got=%0d want=4", acc); end
        push_one(6, 404);
        push_one(5, 405);
        i_deq_req = 1'b1;
        acc = 0;
        repeat (5) begin
            #1;
            if (o_deq_req_ready === 1'b1) acc++;
            tick();
        end
        total++; if (acc != 0) begin bad++; $display("FAIL credit_block got=%0d want=0", acc); end
        i_deq_ready = 1'b1;
        adm = 0;
        first_adm = -1;
        n = 0;
        for (int c = 0; c < 30 && n < 6; c++) begin
            #1;
            if (o_deq_valid === 1'b1) begin got[n] = int'(o_deq_data[PTW-1:0]); n++; $display("drain prio=%0d cycle=%0d", o_deq_data[PTW-1:0], c); end
            if (o_deq_req_ready === 1'b1) begin if (adm == 0) first_adm = c; adm++; end
            tick();
        end
        i_deq_req   = 1'b0;
        i_deq_ready = 1'b0;
        total++; if (n != 6) begin bad++; $display("FAIL credit_drained got=%0d want=6", n); end
        else begin
            for (int k = 0; k < 6; k++) begin
                total++; if (got[k] != k + 1) begin bad++; $display("FAIL credit_order%0d got=%0d want=%0d", k, got[k], k + 1); end
            end
        end
        total++; if (adm != 2 || first_adm != 1) begin bad++; $display("FAIL credit_admit got=%0d@%0d want=2@1", adm, first_adm); end
        total++; if (o_count !== CW'(0)) begin bad++; $display("FAIL credit_count got=%0d want=0", o_count); end
    endtask

    task automatic test_reset_midflight();
        push_one(7, 500);
        push_one(8, 501);
        i_deq_req = 1'b1;
        #1;
        total++; if (o_pop !== 1'b1) begin bad++; $display("FAIL midrst_pop got=%0b want=1", o_pop); end
        tick();
        i_deq_req   = 1'b0;
        i_deq_ready = 1'b0;
        i_rst       = 1'b1;
        tick();
        i_rst = 1'b0;
        $display("reset during in-flight pop");
        for (int c = 0; c < 6; c++) begin
            #1;
            total++; if (o_deq_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid%0d got=%0b want=0", c, o_deq_valid); end
            total++; if (o_count !== CW'(0)) begin bad++; $display("FAIL midrst_count%0d got=%0d want=0", c, o_count); end
            tick();
        end
    endtask

    task automatic test_pifo_stall();
        push_one(8, 600);
        push_one(9, 601);
        i_pifo_ready = 1'b0;
        i_enq_valid  = 1'b1;
        i_enq_data   = mk(3, 602);
        i_deq_req    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (o_push !== 1'b0 || o_pop !== 1'b0) begin bad++; $display("FAIL stall_cmd%0d got=%0b%0b want=00", c, o_push, o_pop); end
            total++; if (o_count !== CW'(2)) begin bad++; $display("FAIL stall_count%0d got=%0d want=2", c, o_count); end
            tick();
        end
        i_pifo_ready = 1'b1;
        i_enq_valid  = 1'b0;
        i_deq_req    = 1'b0;
        $display("stall released count=%0d", o_count);
        pop_all();
        total++; if (o_count !== CW'(0)) begin bad++; $display("FAIL stall_drain got=%0d want=0", o_count); end
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_alternate();
        test_full();
        test_credit();
        test_reset_midflight();
        test_pifo_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
